// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants and types used by the opcode decoder and the program encoder.
package mips_pkg;

    typedef enum logic [2:0] {
        CLS_RTYPE = 3'd0,
        CLS_LW    = 3'd1,
        CLS_SW    = 3'd2,
        CLS_BEQ   = 3'd3,
        CLS_BNE   = 3'd4,
        CLS_J     = 3'd5
    } instr_class_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    function automatic logic funct_legal(input logic [5:0] funct);
        logic ok;
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/imem_program_encoder_instr_pack.sv
// Combinational packer: symbolic descriptor plus current write pointer -> 32-bit MIPS word.
module instr_pack
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [2:0]        i_class,
    input  logic [5:0]        i_funct,
    input  logic [4:0]        i_rs,
    input  logic [4:0]        i_rt,
    input  logic [4:0]        i_rd,
    input  logic [15:0]       i_imm,
    input  logic [ADDR_W-1:0] i_target,
    input  logic [ADDR_W-1:0] i_ptr,
    output logic [31:0]       o_word,
    output logic              o_illegal
);

    localparam int OW = ADDR_W + 2;

    logic [OW-1:0] w_off;
    logic [15:0]   w_off16;
    logic          w_off_ok;
    logic [25:0]   w_jtarget;

    // Branch offset is relative to the word after the branch itself.
    assign w_off     = {2'b00, i_target} - {2'b00, i_ptr} - {{(OW-1){1'b0}}, 1'b1};
    assign w_jtarget = 26'(i_target);

    if (OW < 16) begin : g_sext
        assign w_off16  = {{(16-OW){w_off[OW-1]}}, w_off};
        assign w_off_ok = 1'b1;
    end else if (OW == 16) begin : g_exact
        assign w_off16  = w_off;
        assign w_off_ok = 1'b1;
    end else begin : g_trunc
        assign w_off16  = w_off[15:0];
        assign w_off_ok = (&w_off[OW-1:15]) | ~(|w_off[OW-1:15]);
    end

    // Field packing; anything unencodable leaves the word at zero (nop).
    always_comb begin
        o_word    = 32'h0000_0000;
        o_illegal = 1'b0;
        case (i_class)
            CLS_RTYPE: begin
                if (funct_legal(i_funct)) begin
                    o_word = {OP_RTYPE, i_rs, i_rt, i_rd, 5'd0, i_funct};
                end else begin
                    o_illegal = 1'b1;
                end
            end
            CLS_LW:  o_word = {OP_LW, i_rs, i_rt, i_imm};
            CLS_SW:  o_word = {OP_SW, i_rs, i_rt, i_imm};
            CLS_BEQ, CLS_BNE: begin
                if (w_off_ok) begin
                    o_word = {(i_class == CLS_BEQ) ? OP_BEQ : OP_BNE, i_rs, i_rt, w_off16};
                end else begin
                    o_illegal = 1'b1;
                end
            end
            CLS_J:   o_word = {OP_J, w_jtarget};
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imem_program_encoder.sv
// Program loader: accepts instruction descriptors, encodes them and writes them
// sequentially into instruction memory while the core is held off.
module imem_program_encoder
    import mips_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [5:0]        in_funct,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [ADDR_W-1:0] in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              err,
    output logic [ADDR_W:0]   prog_len
);

    localparam logic [ADDR_W-1:0] BASE_L  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);

    enc_state_e        r_state;
    enc_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_len;
    logic              r_full;
    logic              r_err;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic [31:0]       w_word;
    logic              w_illegal;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_start_load;

    instr_pack #(.ADDR_W(ADDR_W)) u_pack (
        .i_class   (in_class),
        .i_funct   (in_funct),
        .i_rs      (in_rs),
        .i_rt      (in_rt),
        .i_rd      (in_rd),
        .i_imm     (in_imm),
        .i_target  (in_target),
        .i_ptr     (r_ptr),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    assign w_in_ready   = (r_state == ST_LOAD) && !r_full;
    assign w_accept     = in_valid && w_in_ready;
    assign w_start_load = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // Next-state logic; start during a load and finish outside a load are ignored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_LOAD;
                else       w_state_nxt = ST_IDLE;
            end
            ST_LOAD: begin
                if (finish) w_state_nxt = ST_DRAIN;
                else        w_state_nxt = ST_LOAD;
            end
            ST_DRAIN: w_state_nxt = ST_DONE;
            ST_DONE: begin
                if (start) w_state_nxt = ST_LOAD;
                else       w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Write pointer, length, sticky flags and the single output register stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr   <= BASE_L;
            r_len   <= '0;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= BASE_L;
            r_wdata <= 32'h0000_0000;
        end else begin
            r_we <= 1'b0;
            if (w_start_load) begin
                r_ptr  <= BASE_L;
                r_len  <= '0;
                r_full <= 1'b0;
                r_err  <= 1'b0;
            end else if (w_accept) begin
                r_we    <= 1'b1;
                r_addr  <= r_ptr;
                r_wdata <= w_word;
                r_ptr   <= r_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
                r_len   <= r_len + {{ADDR_W{1'b0}}, 1'b1};
                r_full  <= ((r_len + {{ADDR_W{1'b0}}, 1'b1}) == DEPTH_L);
                r_err   <= r_err | w_illegal;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign busy       = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
    assign done       = (r_state == ST_DONE);
    assign full       = r_full;
    assign err        = r_err;
    assign prog_len   = r_len;

endmodule

// File: doc/imem_program_encoder.md
Name: imem_program_encoder

Overview:
- Encoder/writer counterpart to the opcode decoder in the single-cycle MIPS core.
- Accepts symbolic instruction descriptors (class, registers, immediate, absolute branch/jump target) over a valid/ready stream.
- Packs each descriptor into a 32-bit MIPS word for the supported subset: R-type add/sub/and/or/slt, LW, SW, BEQ, BNE, J.
- Writes the words sequentially into instruction memory while the core is held off. Used by the testbench/boot path to load programs.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- DEPTH, 256, number of writable words (must be <= 2**ADDR_W).
- BASE_ADDR, 0, word address of the first instruction written.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: begin a new program load.
- finish  in  1  one-cycle pulse: end the program load.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  encoder can accept a descriptor.
- in_class  in  3  0=RTYPE, 1=LW, 2=SW, 3=BEQ, 4=BNE, 5=J; 6 and 7 are illegal.
- in_funct  in  6  R-type funct code.
- in_rs  in  5  rs field.
- in_rt  in  5  rt field.
- in_rd  in  5  rd field.
- in_imm  in  16  LW/SW offset, signed.
- in_target  in  ADDR_W  absolute word address for BEQ/BNE/J.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  load in progress; core must stay halted.
- done  out  1  load complete; sticky until the next start.
- full  out  1  DEPTH words written.
- err  out  1  sticky: illegal class/funct or branch out of range.
- prog_len  out  ADDR_W+1  number of words written.

Behaviour:
- Reset (async, active-low):
  - FSM goes to IDLE.
  - Outputs: in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, busy=0, done=0, full=0, err=0, prog_len=0.
- FSM states and transitions:
  - IDLE → LOAD on start. On entry: write pointer=BASE_ADDR, prog_len=0, err=0, done=0, full=0.
  - LOAD → DRAIN on finish. Handshake rules while in LOAD follow below.
  - DRAIN → DONE after one cycle, once the output register has emitted its last write.
  - DONE → LOAD on start.
- Handshake (LOAD):
  - in_ready=1 in LOAD when !full; 0 in all other states.
  - A descriptor is accepted when in_valid && in_ready on a rising edge.
- Output pipeline: one register stage.
  - An accepted descriptor produces imem_we=1 with imem_addr=ptr and imem_wdata=encoded on the next cycle.
  - ptr, prog_len and full update in that same cycle.
  - Back-to-back acceptance gives one write per cycle.
- Encoding:
  - RTYPE: {6'h00, rs, rt, rd, 5'd0, funct}. funct must be one of 20h, 22h, 24h, 25h, 2Ah.
  - LW: {6'h23, rs, rt, imm}.
  - SW: {6'h2B, rs, rt, imm}.
  - BEQ: {6'h04, rs, rt, off}; BNE: {6'h05, rs, rt, off}.
    - off = target − (ptr+1), computed in ADDR_W+2-bit signed arithmetic and sign-extended to 16 bits.
    - Out of range when the offset does not fit in signed 16 bits (only possible when ADDR_W ≥ 16).
  - J: {6'h02, 26-bit zero-extended target}.
- Error handling:
  - Illegal class, illegal funct or out-of-range offset: word is written as 32'h0 (nop), err=1 (sticky), ptr still advances.
- full: set when prog_len reaches DEPTH. Further in_valid is back-pressured, not dropped, and no write occurs.
- Simultaneous events:
  - finish and an accepted descriptor in the same cycle: the descriptor is written, then the FSM goes to DRAIN.
  - start while in LOAD: ignored.
  - finish while in IDLE: ignored.
- busy=1 in LOAD and DRAIN.
- done rises in the cycle the FSM enters DONE.
- Reset mid-load aborts immediately; no imem_we is issued after reset is asserted.

Decomposition:
- Shared package mips_pkg holds:
  - class enum (RTYPE..J);
  - opcode constants (00h, 23h, 2Bh, 04h, 05h, 02h);
  - funct constants (ADD=20h, SUB=22h, AND=24h, OR=25h, SLT=2Ah).
- These are the same constants the opcode decoder uses.
- One natural sub-module: instr_pack, a purely combinational descriptor + ptr → {word, illegal} packer.
- The top level holds the FSM, pointer/counter and output register.

Test Plan:
- Reset, start, RTYPE rs=1 rt=2 rd=3 funct=20h → next cycle imem_we=1, addr=0, wdata=00221820h, prog_len=1.
- LW rs=16 rt=8 imm=4 then SW rs=1 rt=2 imm=8, back-to-back → writes 8E080004h @0 and AC220008h @1 on consecutive cycles.
- Three R-type nops, then BEQ rs=1 rt=2 target=0 at ptr=3 → wdata 1022FFFCh; J target=5 at ptr=4 → 08000005h.
- in_class=7 or funct=21h → wdata 00000000h, err=1, ptr advances; err stays set until next start.
- DEPTH=4: push 5 valid descriptors → 4 writes, full=1, in_ready=0, 5th held with in_valid=1 and no write; finish → done=1 after 2 cycles, prog_len=4.
- Assert reset during LOAD with in_valid=1 → all outputs return to reset values asynchronously, no further imem_we; start again → writes from BASE_ADDR.
